// File: rtl/rps_result_scoreboard.sv
// Purpose: decode judge result bytes into per-player scores, tallies and a first-to-WIN_TARGET match winner.
// Latency: every output updates on the accepting edge, so results are visible one cycle after the handshake.
// Backpressure: res_ready is low while the match is over, while ena is low, or while clear is high.
module rps_result_scoreboard #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               res_valid,
    input  logic [7:0]         res_byte,
    output logic               res_ready,
    input  logic               clear,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [7:0]         tie_count,
    output logic [7:0]         inval_count,
    output logic [7:0]         round_count,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               err_flag
);

    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] ONE    = SCORE_W'(1);

    typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

    state_t             state;
    logic               accept;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    assign res_ready = (state == PLAY) && ena && !clear;
    assign accept    = res_valid && res_ready;
    assign p1_next   = p1_score + ONE;
    assign p2_next   = p2_score + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PLAY;
            p1_score     <= '0;
            p2_score     <= '0;
            tie_count    <= 8'd0;
            inval_count  <= 8'd0;
            round_count  <= 8'd0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
            err_flag     <= 1'b0;
        end else if (clear) begin
            // Clear wins over everything, including a pending byte; res_ready is low this cycle.
            state        <= PLAY;
            p1_score     <= '0;
            p2_score     <= '0;
            tie_count    <= 8'd0;
            inval_count  <= 8'd0;
            round_count  <= 8'd0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
            err_flag     <= 1'b0;
        end else if (accept) begin
            if (round_count != 8'hFF) begin
                round_count <= round_count + 8'd1;
            end
            case (res_byte)
                8'h31: begin
                    p1_score <= p1_next;
                    if (p1_next == TARGET) begin
                        state        <= OVER;
                        match_over   <= 1'b1;
                        match_winner <= 2'b01;
                    end
                end
                8'h32: begin
                    p2_score <= p2_next;
                    if (p2_next == TARGET) begin
                        state        <= OVER;
                        match_over   <= 1'b1;
                        match_winner <= 2'b10;
                    end
                end
                8'h00: begin
                    if (tie_count != 8'hFF) begin
                        tie_count <= tie_count + 8'd1;
                    end
                end
                8'h3F: begin
                    if (inval_count != 8'hFF) begin
                        inval_count <= inval_count + 8'd1;
                    end
                end
                default: err_flag <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/rps_result_scoreboard.md
Name: rps_result_scoreboard

Overview:
Consumer end of the stone-paper-scissors judge output. It accepts the judge's ASCII result byte over a valid/ready handshake and decodes it back to a round outcome. It keeps per-player scores and tie/invalid tallies, and declares a first-to-WIN_TARGET match winner. It sits between the judge output and the display/host logic, and holds the final result until cleared.

Parameters:
WIN_TARGET, 3, round wins needed to take the match; legal range 1..(2^SCORE_W - 1).
SCORE_W, 4, width of each player score counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  block enable; when 0 no byte is accepted and state holds.
res_valid  input  1  result byte present on res_byte.
res_byte  input  8  ASCII result: 0x00 tie, 0x31 P1 wins, 0x32 P2 wins, 0x3F invalid moves.
res_ready  output  1  block can accept a byte this cycle.
clear  input  1  synchronous match restart.
p1_score  output  SCORE_W  player 1 round wins.
p2_score  output  SCORE_W  player 2 round wins.
tie_count  output  8  tied rounds, saturating.
inval_count  output  8  0x3F rounds, saturating.
round_count  output  8  accepted bytes of any value, saturating.
match_over  output  1  a player has reached WIN_TARGET.
match_winner  output  2  00 none, 01 P1, 10 P2; 11 is never driven.
err_flag  output  1  sticky: a byte outside the four legal codes was accepted.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = PLAY.
  - All counters = 0.
  - match_over = 0, match_winner = 00, err_flag = 0.
  - res_ready follows its equation, so it is 1 after reset if ena=1 and clear=0.
- FSM has two states, PLAY and OVER.
- res_ready is combinational: (state==PLAY) && ena && !clear.
- Accept occurs when res_valid && res_ready at a rising edge. Every output updates on that same edge, so outputs are visible one cycle after the handshake. There is no internal buffering.
- Decode on accept (round_count increments for every accepted byte, saturating at 255):
  - 0x31: p1_score += 1.
  - 0x32: p2_score += 1.
  - 0x00: tie_count += 1, saturating at 255.
  - 0x3F: inval_count += 1, saturating at 255.
  - Any other value: err_flag <= 1 and no score or tally changes.
- Transition PLAY->OVER happens on the accepting edge where the incremented score equals WIN_TARGET.
  - match_over <= 1 and match_winner <= 01 or 10 on that same edge.
  - Scores never exceed WIN_TARGET, so no wrap is possible.
- In OVER, res_ready = 0 and all counters hold.
- clear=1 at an edge, in any state:
  - All counters, err_flag and match_winner go to 0; match_over goes to 0; state goes to PLAY.
  - clear has priority. res_ready is already 0 while clear is high, so no byte is lost mid-handshake and the upstream keeps res_valid asserted.
- ena=0 holds all state; clear still takes effect.
- res_valid is ignored in OVER. The upstream keeps its byte until res_ready returns after clear.
- Asserting rst_n low mid-match forces reset values immediately, independent of clk.
- WIN_TARGET=1: the first decisive byte ends the match.

Test Plan:
- Reset, ena=1, send 0x31, 0x32, 0x31, 0x00 -> p1=2, p2=1, tie=1, round=4, match_over=0, res_ready=1 throughout.
- Send 0x31 three times -> third accept gives match_over=1, winner=01 on that edge. res_ready=0 next cycle. A further 0x32 with res_valid held is not accepted and p2 stays 0.
- Send 0x3F, then 0x41 -> inval=1, err_flag=1, round=2, scores 0. Send 0x32 -> err_flag stays 1.
- Hold res_valid=1 with 0x32 and pulse clear for one cycle in PLAY -> res_ready=0 that cycle, counters cleared, byte accepted on the following cycle, p2=1.
- Drive 300 bytes of 0x00 -> tie_count and round_count saturate at 255, match_over=0.
- Mid-match (p1=2), pulse rst_n low between clock edges -> all outputs zero immediately. Then send 0x32 x3 -> winner=10.
